// File: rtl/corelet_pkg.sv
// corelet_pkg: shared corelet constants -- inst bus bit positions, idle word, sequencer states.
package corelet_pkg;
    localparam int DEF_ROW      = 8;
    localparam int DEF_COL      = 8;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_L0_DEPTH = 64;
    localparam int INST_W        = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_PMEM = 32;
    localparam int INST_WEN_PMEM = 31;
    localparam int INST_A_PMEM   = 20;
    localparam int INST_CEN_XMEM = 19;
    localparam int INST_WEN_XMEM = 18;
    localparam int INST_A_XMEM   = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_LOAD     = 0;
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;
    typedef enum logic [2:0] {
        S_IDLE, S_W_FILL, S_W_LOAD, S_W_GAP, S_A_FILL, S_A_EXEC, S_DRAIN, S_DONE
    } seq_state_e;
    function automatic logic [6:0] sat_n(input logic [6:0] n, input int depth);
        return (int'(n) > depth) ? 7'(depth) : n;
    endfunction
endpackage

// File: rtl/seq_addr_cnt.sv
// seq_addr_cnt: base-plus-offset address generator with issue counter and terminal-count flag.
//  clk, rst_n   clock, asynchronous active-low reset
//  i_load       restart at i_base with count 0 (usable in the same cycle as i_inc)
//  i_base       base address
//  i_inc        an access is issued this cycle at o_addr; advance afterwards
//  i_limit      count at which o_tc rises
//  o_addr       address of the access issued this cycle
//  o_tc         accesses issued so far == i_limit
module seq_addr_cnt #(
    parameter int AW = 11,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_base,
    input  logic          i_inc,
    input  logic [CW-1:0] i_limit,
    output logic [AW-1:0] o_addr,
    output logic          o_tc
);
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_cnt, w_cnt;

    assign o_addr = i_load ? i_base : r_addr;
    assign w_cnt  = i_load ? '0 : r_cnt;
    assign o_tc   = w_cnt == i_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load || i_inc) begin
            r_addr <= o_addr + AW'(i_inc);
            r_cnt  <= w_cnt + CW'(i_inc);
        end
    end
endmodule

// File: rtl/corelet_inst_seq.sv
// corelet_inst_seq: drives the corelet inst bus through weight fill/load, activation fill/execute and psum drain.
//  clk, reset    clock, asynchronous active-low reset
//  start         one-cycle tile start, ignored unless idle
//  w_base/x_base xmem base addresses for weights/activations
//  p_base        pmem base address for psums
//  n_act         activation vectors (saturated to L0_DEPTH)
//  ofifo_valid   corelet ofifo holds a full row
//  inst          registered instruction word
//  busy, done    tile in progress / one-cycle completion pulse
//  perf_cycles   busy-cycle counter, present only with SEQ_PERF_EN defined
module corelet_inst_seq
    import corelet_pkg::*;
#(
    parameter int row      = DEF_ROW,
    parameter int col      = DEF_COL,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int L0_DEPTH = DEF_L0_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [6:0]        n_act,
    input  logic              ofifo_valid,
    output logic [33:0]       inst,
    output logic              busy,
    output logic              done
`ifdef SEQ_PERF_EN
    ,output logic [31:0]      perf_cycles
`endif
);
    seq_state_e        r_state, w_state_nxt;
    logic [6:0]        r_cnt, w_cnt_nxt, r_n, w_x_limit, w_p_limit;
    logic [ADDR_W-1:0] r_x_base, w_x_base, w_x_addr, w_p_addr;
    logic [INST_W-1:0] r_inst, w_inst_nxt;
    logic              w_start, w_x_load, w_x_rd, w_x_tc, w_p_tc, w_rd, w_x_rd_cur, w_rd_cur;

    assign w_start    = start && (r_state == S_IDLE);
    // The word on the bus now tells what the next word must follow up with.
    assign w_x_rd_cur = !r_inst[INST_CEN_XMEM];
    assign w_rd_cur   = r_inst[INST_OFIFO_RD];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_W_FILL;
            S_W_FILL: if (r_cnt == 7'(col)) w_state_nxt = S_W_LOAD;
            S_W_LOAD: if (r_cnt == 7'(col - 1)) w_state_nxt = S_W_GAP;
            S_W_GAP:  if (r_cnt == 7'(row + col - 1)) w_state_nxt = (r_n == '0) ? S_DONE : S_A_FILL;
            S_A_FILL: if (r_cnt == r_n) w_state_nxt = S_A_EXEC;
            S_A_EXEC: if (r_cnt == r_n - 7'd1) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (w_p_tc && !w_rd_cur) w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + 7'd1;
    assign w_x_load  = w_start || (w_state_nxt == S_A_FILL && r_state != S_A_FILL);
    assign w_x_base  = w_start ? w_base : r_x_base;
    assign w_x_limit = (w_state_nxt == S_W_FILL) ? 7'(col) : r_n;
    assign w_x_rd    = (w_state_nxt == S_W_FILL || w_state_nxt == S_A_FILL) && !w_x_tc;
    // A read in flight already owns a psum slot, so it counts against the limit.
    assign w_p_limit = r_n - 7'(w_rd_cur);
    assign w_rd      = (r_state == S_DRAIN) && ofifo_valid && !w_p_tc;

    seq_addr_cnt #(.AW(ADDR_W), .CW(7)) u_x_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_x_load),
        .i_base  (w_x_base),
        .i_inc   (w_x_rd),
        .i_limit (w_x_limit),
        .o_addr  (w_x_addr),
        .o_tc    (w_x_tc)
    );

    seq_addr_cnt #(.AW(ADDR_W), .CW(7)) u_p_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_start),
        .i_base  (p_base),
        .i_inc   (w_rd_cur),
        .i_limit (w_p_limit),
        .o_addr  (w_p_addr),
        .o_tc    (w_p_tc)
    );

    always_comb begin
        w_inst_nxt                           = INST_IDLE;
        w_inst_nxt[INST_CEN_XMEM]            = !w_x_rd;
        w_inst_nxt[INST_A_XMEM +: ADDR_W]    = w_x_rd ? w_x_addr : '0;
        w_inst_nxt[INST_L0_WR]               = w_x_rd_cur;
        w_inst_nxt[INST_L0_RD]               = w_state_nxt == S_W_LOAD || w_state_nxt == S_A_EXEC;
        w_inst_nxt[INST_LOAD]                = w_state_nxt == S_W_LOAD;
        w_inst_nxt[INST_EXECUTE]             = w_state_nxt == S_A_EXEC;
        w_inst_nxt[INST_OFIFO_RD]            = w_rd;
        w_inst_nxt[INST_CEN_PMEM]            = !w_rd_cur;
        w_inst_nxt[INST_WEN_PMEM]            = !w_rd_cur;
        w_inst_nxt[INST_A_PMEM +: ADDR_W]    = w_rd_cur ? w_p_addr : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_n      <= '0;
            r_x_base <= '0;
            r_inst   <= INST_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_inst  <= w_inst_nxt;
            if (w_start) begin
                r_n      <= sat_n(n_act, L0_DEPTH);
                r_x_base <= x_base;
            end
        end
    end

    assign inst = r_inst;
    assign busy = r_state != S_IDLE;
    assign done = r_state == S_DONE;

`ifdef SEQ_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_perf <= '0;
        else if (w_start)
            r_perf <= '0;
        else if (busy)
            r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`endif
endmodule
